// File: rtl/dram_check_model.sv
// DRAM model and output checker for the accelerator top level.
// Serves ifmap reads through a READ_LAT-deep pipeline, captures byte-packed
// pooled output writes, and once the final output word lands runs a
// byte-serial tolerance compare against preloaded golden data.
module dram_check_model #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 10,
  parameter int READ_LAT  = 1,
  parameter int OUT_BYTES = 196,
  parameter int DONE_ADDR = 25,
  parameter int TOL       = 1,
  parameter int CNT_W     = $clog2(OUT_BYTES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              gld_we,
  input  logic [CNT_W-1:0]  gld_addr,
  input  logic [7:0]        gld_wdata,
  input  logic              DRAMreadEn,
  input  logic [ADDR_W-1:0] DRAMreadAddr,
  input  logic              DRAMwriteEn,
  input  logic [ADDR_W-1:0] DRAMwriteAddr,
  input  logic [DATA_W-1:0] DRAMwriteData,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  first_err,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [31:0]       cycle_cnt
);

  localparam int LANES = DATA_W / 8;
  localparam int IDX_W = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;

  localparam logic [CNT_W-1:0]  OUT_BYTES_C = CNT_W'(OUT_BYTES);
  localparam logic [CNT_W-1:0]  LAST_IDX    = CNT_W'(OUT_BYTES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
  localparam logic [7:0]        TOL_B       = 8'(TOL);
  localparam logic [ADDR_W-1:0] DONE_A      = ADDR_W'(DONE_ADDR);

  typedef enum logic [1:0] {
    S_RUN,
    S_CHECK,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] mem     [2**ADDR_W];
  logic [7:0]        gld_mem [OUT_BYTES];
  logic [7:0]        cap_mem [OUT_BYTES];

  logic [READ_LAT-1:0] rd_v;
  logic [DATA_W-1:0]   rd_d [READ_LAT];

  logic             cap_we;
  logic             trigger;
  logic [LANES-1:0] lane_ok;
  logic [IDX_W-1:0] lane_idx [LANES];
  int               drop_n;
  int               drop_sum;
  logic [CNT_W-1:0] drop_next;

  logic [CNT_W-1:0] idx;
  logic [7:0]       cap_b;
  logic [7:0]       gld_b;
  logic [7:0]       diff;
  logic             byte_ok;

  // Preload ports for ifmap and golden data, accepted in every state.
  // NOTE: storage arrays carry no reset so they map onto RAM and keep their
  // contents across rst; only control state is reset.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_addr] <= mem_wdata;
    if (gld_we && (gld_addr < OUT_BYTES_C))
      gld_mem[IDX_W'(gld_addr)] <= gld_wdata;
  end

  // Read pipeline: stage 0 samples the array, later stages only advance
  // behind a valid word so rdata holds its last value between pulses.
  // NOTE: non-blocking assignments make a same-cycle preload write invisible
  // to the read, which therefore returns the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v <= '0;
      for (int s = 0; s < READ_LAT; s++) rd_d[s] <= '0;
    end else begin
      rd_v[0] <= DRAMreadEn;
      if (DRAMreadEn) rd_d[0] <= mem[DRAMreadAddr];
      for (int s = 1; s < READ_LAT; s++) begin
        rd_v[s] <= rd_v[s-1];
        if (rd_v[s-1]) rd_d[s] <= rd_d[s-1];
      end
    end
  end

  assign rdata  = rd_d[READ_LAT-1];
  assign rvalid = rd_v[READ_LAT-1];

  assign cap_we  = (state == S_RUN) && DRAMwriteEn;
  assign trigger = cap_we && (DRAMwriteAddr == DONE_A);

  // Per-lane byte index of the incoming write and the count of lanes past
  // the end of the checked output region.
  // NOTE: every always_comb output gets a value before any condition, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    drop_n = 0;
    lane_ok = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_ok[k]  = (int'(DRAMwriteAddr) * LANES + k) < OUT_BYTES;
      lane_idx[k] = IDX_W'(int'(DRAMwriteAddr) * LANES + k);
      if (!lane_ok[k]) drop_n = drop_n + 1;
    end
    drop_sum  = int'(drop_cnt) + drop_n;
    drop_next = (drop_sum > int'(CNT_MAX)) ? CNT_MAX : CNT_W'(drop_sum);
  end

  // Output capture: each in-range byte lane lands at its own byte index.
  always_ff @(posedge clk) begin
    if (cap_we) begin
      for (int k = 0; k < LANES; k++)
        if (lane_ok[k]) cap_mem[lane_idx[k]] <= DRAMwriteData[8*k +: 8];
    end
  end

  // Absolute byte difference as max - min so it never wraps.
  always_comb begin
    cap_b   = cap_mem[IDX_W'(idx)];
    gld_b   = gld_mem[IDX_W'(idx)];
    diff    = (cap_b >= gld_b) ? (cap_b - gld_b) : (gld_b - cap_b);
    byte_ok = (diff <= TOL_B);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_RUN;
    else     state <= state_next;
  end

  // Next-state: RUN until the trigger write, CHECK for OUT_BYTES cycles,
  // then DONE until reset.
  always_comb begin
    state_next = state;
    unique case (state)
      S_RUN:   if (trigger) state_next = S_CHECK;
      S_CHECK: if (idx == LAST_IDX) state_next = S_DONE;
      S_DONE:  state_next = S_DONE;
      default: state_next = S_RUN;
    endcase
  end

  // Run statistics and compare results.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      pass_cnt  <= '0;
      err_cnt   <= '0;
      first_err <= OUT_BYTES_C;
      drop_cnt  <= '0;
      cycle_cnt <= '0;
    end else begin
      if (state == S_RUN) cycle_cnt <= cycle_cnt + 32'd1;
      if (cap_we)         drop_cnt  <= drop_next;
      if (state == S_CHECK) begin
        idx <= idx + CNT_W'(1);
        if (byte_ok) begin
          pass_cnt <= pass_cnt + CNT_W'(1);
        end else begin
          err_cnt <= err_cnt + CNT_W'(1);
          if (err_cnt == '0) first_err <= idx;
        end
      end
    end
  end

  assign busy = (state == S_CHECK);
  assign done = (state == S_DONE);
  assign pass = done && (err_cnt == '0);

endmodule

// File: tb/tb_dram_check_model.sv
// Directed bench for dram_check_model: read latency/ordering through a
// scoreboard queue, then clean, tolerance, underflow and aborted checks.
module tb_dram_check_model;

  localparam int DATA_W    = 64;
  localparam int ADDR_W    = 10;
  localparam int READ_LAT  = 3;
  localparam int OUT_BYTES = 196;
  localparam int DONE_ADDR = 25;
  localparam int TOL       = 1;
  localparam int CNT_W     = 8;
  localparam int LANES     = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              gld_we;
  logic [CNT_W-1:0]  gld_addr;
  logic [7:0]        gld_wdata;
  logic              DRAMreadEn;
  logic [ADDR_W-1:0] DRAMreadAddr;
  logic              DRAMwriteEn;
  logic [ADDR_W-1:0] DRAMwriteAddr;
  logic [DATA_W-1:0] DRAMwriteData;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              busy;
  logic              done;
  logic              pass;
  logic [CNT_W-1:0]  pass_cnt;
  logic [CNT_W-1:0]  err_cnt;
  logic [CNT_W-1:0]  first_err;
  logic [CNT_W-1:0]  drop_cnt;
  logic [31:0]       cycle_cnt;

  dram_check_model #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .READ_LAT (READ_LAT),
    .OUT_BYTES(OUT_BYTES),
    .DONE_ADDR(DONE_ADDR),
    .TOL      (TOL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .gld_we       (gld_we),
    .gld_addr     (gld_addr),
    .gld_wdata    (gld_wdata),
    .DRAMreadEn   (DRAMreadEn),
    .DRAMreadAddr (DRAMreadAddr),
    .DRAMwriteEn  (DRAMwriteEn),
    .DRAMwriteAddr(DRAMwriteAddr),
    .DRAMwriteData(DRAMwriteData),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .pass_cnt     (pass_cnt),
    .err_cnt      (err_cnt),
    .first_err    (first_err),
    .drop_cnt     (drop_cnt),
    .cycle_cnt    (cycle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    int          due;
  } rd_exp_t;

  rd_exp_t rd_q[$];

  int tests     = 0;
  int fails     = 0;
  int edge_ctr  = 0;
  int run_edges = 0;
  int exp_cyc   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: score any read return at the falling edge, then advance past
  // the rising edge. due is the edge after which the word must be visible.
  task automatic step();
    logic    exp_v;
    rd_exp_t e;
    @(negedge clk);
    exp_v = (rd_q.size() > 0) && (rd_q[0].due == edge_ctr);
    if (rvalid || exp_v) begin
      check("rvalid", 64'(rvalid), 64'(exp_v));
      if (exp_v) begin
        e = rd_q.pop_front();
        if (rvalid) check("rdata", rdata, e.data);
      end
    end
    @(posedge clk);
    if (rst) run_edges = 0;
    else     run_edges++;
    edge_ctr++;
    #1;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic [63:0] expd);
    DRAMreadEn   = 1'b1;
    DRAMreadAddr = a;
    rd_q.push_back('{data: expd, due: edge_ctr + READ_LAT});
    step();
    DRAMreadEn = 1'b0;
  endtask

  task automatic wr_cap(input logic [ADDR_W-1:0] a, input logic [63:0] d);
    DRAMwriteEn   = 1'b1;
    DRAMwriteAddr = a;
    DRAMwriteData = d;
    step();
    DRAMwriteEn = 1'b0;
  endtask

  // Golden rule: byte i holds i mod 256; capture word w spans bytes 8w..8w+7.
  function automatic logic [63:0] cap_word(input int w);
    logic [63:0] v;
    for (int k = 0; k < LANES; k++) v[8*k +: 8] = 8'(8 * w + k);
    return v;
  endfunction

  task automatic trigger();
    wr_cap(ADDR_W'(DONE_ADDR), cap_word(DONE_ADDR));
    exp_cyc = run_edges;
    check("trig_busy", 64'(busy), 64'd1);
    check("trig_cycle_cnt", 64'(cycle_cnt), 64'(exp_cyc));
  endtask

  // Counts busy cycles (bounded); optional writes during CHECK must be ignored.
  task automatic run_check(input bit poke, output int n);
    n = 0;
    while (busy && n < 400) begin
      n++;
      if (poke && n == 1) begin
        DRAMwriteEn = 1'b1; DRAMwriteAddr = '0; DRAMwriteData = '1;
      end
      if (poke && n == 2) begin
        DRAMwriteEn = 1'b1; DRAMwriteAddr = ADDR_W'(DONE_ADDR); DRAMwriteData = '1;
      end
      step();
      DRAMwriteEn = 1'b0;
    end
  endtask

  task automatic check_final(input string p, input int n, input int ep, input int ee,
                             input int ef, input int epass, input int edrop);
    check({p, "_busy_cycles"}, 64'(n), 64'(OUT_BYTES));
    check({p, "_done"}, 64'(done), 64'd1);
    check({p, "_busy"}, 64'(busy), 64'd0);
    check({p, "_pass"}, 64'(pass), 64'(epass));
    check({p, "_pass_cnt"}, 64'(pass_cnt), 64'(ep));
    check({p, "_err_cnt"}, 64'(err_cnt), 64'(ee));
    check({p, "_first_err"}, 64'(first_err), 64'(ef));
    check({p, "_drop_cnt"}, 64'(drop_cnt), 64'(edrop));
    check({p, "_cycle_cnt"}, 64'(cycle_cnt), 64'(exp_cyc));
  endtask

  task automatic check_idle(input string p);
    check({p, "_busy"}, 64'(busy), 64'd0);
    check({p, "_done"}, 64'(done), 64'd0);
    check({p, "_pass"}, 64'(pass), 64'd0);
    check({p, "_pass_cnt"}, 64'(pass_cnt), 64'd0);
    check({p, "_err_cnt"}, 64'(err_cnt), 64'd0);
    check({p, "_first_err"}, 64'(first_err), 64'(OUT_BYTES));
    check({p, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
    check({p, "_cycle_cnt"}, 64'(cycle_cnt), 64'd0);
    check({p, "_rvalid"}, 64'(rvalid), 64'd0);
    check({p, "_rdata"}, rdata, 64'd0);
  endtask

  task automatic do_reset(input string p);
    rst = 1'b1;
    step();
    check_idle(p);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, fails=%0d", fails);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n;
    logic [63:0] w;

    rst = 1'b1;
    mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    gld_we = 1'b0; gld_addr = '0; gld_wdata = '0;
    DRAMreadEn = 1'b0; DRAMreadAddr = '0;
    DRAMwriteEn = 1'b0; DRAMwriteAddr = '0; DRAMwriteData = '0;
    step();
    step();
    check_idle("reset");
    rst = 1'b0;

    // Ifmap preload.
    mem_we = 1'b1;
    mem_addr = 10'd5; mem_wdata = 64'h0123_4567_89AB_CDEF; step();
    for (int i = 0; i < 4; i++) begin
      mem_addr = ADDR_W'(i); mem_wdata = 64'hC0DE_0000_0000_0000 + 64'(i) * 64'h1_0001;
      step();
    end
    mem_addr = 10'd6; mem_wdata = 64'hAAAA_0000_0000_0006; step();
    mem_we = 1'b0;

    // Single read: rvalid exactly one cycle, READ_LAT edges after the request.
    rd(10'd5, 64'h0123_4567_89AB_CDEF);
    for (int i = 0; i < 5; i++) step();
    check("rdata_hold", rdata, 64'h0123_4567_89AB_CDEF);
    check("rvalid_idle", 64'(rvalid), 64'd0);

    // Back-to-back reads: consecutive returns in request order.
    for (int i = 0; i < 4; i++) rd(ADDR_W'(i), 64'hC0DE_0000_0000_0000 + 64'(i) * 64'h1_0001);
    for (int i = 0; i < 5; i++) step();

    // Read colliding with a preload write returns the old word.
    mem_we = 1'b1; mem_addr = 10'd6; mem_wdata = 64'hBBBB_0000_0000_0006;
    rd(10'd6, 64'hAAAA_0000_0000_0006);
    mem_we = 1'b0;
    rd(10'd6, 64'hBBBB_0000_0000_0006);
    for (int i = 0; i < 5; i++) step();
    check("rd_queue_empty", 64'(rd_q.size()), 64'd0);

    // Golden preload; the out-of-range index must be ignored.
    gld_we = 1'b1;
    for (int i = 0; i < OUT_BYTES; i++) begin
      gld_addr = CNT_W'(i); gld_wdata = 8'(i); step();
    end
    gld_addr = 8'd200; gld_wdata = 8'hEE; step();
    gld_we = 1'b0;

    // Clean pass. drop_cnt = bytes 196..199 of word 24 plus all 8 bytes of
    // the trigger word 25 (200..207) = 12.
    for (int i = 0; i < 25; i++) wr_cap(ADDR_W'(i), cap_word(i));
    trigger();
    run_check(1'b1, n);
    check_final("clean", n, 196, 0, 196, 1, 12);
    for (int i = 0; i < 3; i++) step();
    check("clean_done_sticky", 64'(done), 64'd1);
    check("clean_cycle_frozen", 64'(cycle_cnt), 64'(exp_cyc));

    // Tolerance: byte 10 off by 1 (ok), byte 11 off by 2 (error).
    do_reset("rst_tol");
    w = cap_word(1);
    w[8*2 +: 8] = 8'd11;
    w[8*3 +: 8] = 8'd13;
    wr_cap(10'd1, w);
    trigger();
    run_check(1'b0, n);
    check_final("tol", n, 195, 1, 11, 0, 8);

    // Underflow: golden 0 vs capture 255 is a diff of 255, not 1.
    do_reset("rst_under");
    wr_cap(10'd1, cap_word(1));
    w = cap_word(0);
    w[7:0] = 8'hFF;
    wr_cap(10'd0, w);
    trigger();
    run_check(1'b0, n);
    check_final("under", n, 195, 1, 0, 0, 8);

    // Reset during CHECK at i=50, then a full rerun on retained capture.
    do_reset("rst_abort");
    wr_cap(10'd0, cap_word(0));
    trigger();
    for (int i = 0; i < 50; i++) step();
    check("abort_mid_busy", 64'(busy), 64'd1);
    check("abort_mid_pass_cnt", 64'(pass_cnt), 64'd50);
    rst = 1'b1;
    step();
    check_idle("abort");
    rst = 1'b0;
    trigger();
    run_check(1'b0, n);
    check_final("rerun", n, 196, 0, 196, 1, 8);
    check("final_rd_queue_empty", 64'(rd_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
